// File: rtl/reg_seq_pkg.sv
// Shared state encoding and counter width for the register-number sequencer.
package reg_seq_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/reg_seq_stepper.sv
// Latches direction/stride at sequence start, tracks the step count and
// produces the next register number plus its wrap (overflow) condition.
module reg_seq_stepper
  import reg_seq_pkg::*;
#(
  parameter int REG_W    = 5,
  parameter int START    = 8,
  parameter int STRIDE_W = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                load,
  input  logic                step,
  input  logic                direction,
  input  logic [STRIDE_W-1:0] stride,
  output logic [CNT_W-1:0]    cnt_o,
  output logic [REG_W-1:0]    regnum_nxt_o,
  output logic                ovf_nxt_o
);

  localparam int OFF_W = CNT_W + STRIDE_W;
  localparam int SUM_W = ((REG_W > OFF_W) ? REG_W : OFF_W) + 1;

  logic                dir_q;
  logic [STRIDE_W-1:0] s_q;
  logic [CNT_W-1:0]    cnt_q;

  logic                eff_dir;
  logic [STRIDE_W-1:0] eff_s;
  logic [CNT_W-1:0]    cnt_d;
  logic [OFF_W-1:0]    off;
  logic [SUM_W-1:0]    start_w;
  logic [SUM_W-1:0]    true_up;

  // On load the live inputs are used so the first RUN value needs no extra cycle.
  always_comb begin
    eff_dir = load ? direction : dir_q;
    eff_s   = load ? ((stride == '0) ? STRIDE_W'(1) : stride) : s_q;
    cnt_d   = load ? CNT_W'(1) : cnt_q + CNT_W'(1);
    off     = OFF_W'(cnt_d) * OFF_W'(eff_s);
    start_w = SUM_W'(START);
    true_up = start_w + SUM_W'(off);
    if (eff_dir) begin
      regnum_nxt_o = REG_W'(START) + REG_W'(off);
      ovf_nxt_o    = true_up > SUM_W'((1 << REG_W) - 1);
    end else begin
      regnum_nxt_o = REG_W'(START) - REG_W'(off);
      ovf_nxt_o    = SUM_W'(off) > start_w;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dir_q <= 1'b0;
      s_q   <= '0;
      cnt_q <= '0;
    end else if (load) begin
      dir_q <= direction;
      s_q   <= eff_s;
      cnt_q <= cnt_d;
    end else if (step) begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/reg_sequencer.sv
// Register-number sequencer: emits START, then STEPS strided numbers with wr_en, then done.
// Optional abort input enabled by defining REG_SEQ_ABORT_EN.
module reg_sequencer
  import reg_seq_pkg::*;
#(
  parameter int REG_W    = 5,
  parameter int START    = 8,
  parameter int STEPS    = 4,
  parameter int STRIDE_W = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                go,
`ifdef REG_SEQ_ABORT_EN
  input  logic                abort,
`endif
  input  logic                direction,
  input  logic [STRIDE_W-1:0] stride,
  output logic [REG_W-1:0]    regnum,
  output logic                wr_en,
  output logic                busy,
  output logic                done,
  output logic                overflow
);

  state_e             state_q;
  logic [REG_W-1:0]   regnum_q;
  logic               wr_en_q;
  logic               busy_q;
  logic               done_q;
  logic               overflow_q;

  logic               abort_w;
  logic               load;
  logic               step;
  logic               last_step;
  logic [CNT_W-1:0]   cnt;
  logic [REG_W-1:0]   regnum_nxt;
  logic               ovf_nxt;

`ifdef REG_SEQ_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  assign last_step = (cnt == CNT_W'(STEPS));
  assign load      = (state_q == S_START) && !go && !abort_w;
  assign step      = (state_q == S_RUN) && !last_step && !abort_w;

  reg_seq_stepper #(
    .REG_W    (REG_W),
    .START    (START),
    .STRIDE_W (STRIDE_W)
  ) u_stepper (
    .clock        (clock),
    .reset        (reset),
    .load         (load),
    .step         (step),
    .direction    (direction),
    .stride       (stride),
    .cnt_o        (cnt),
    .regnum_nxt_o (regnum_nxt),
    .ovf_nxt_o    (ovf_nxt)
  );

  // Outputs are computed for the state being entered, so they are all registered.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      regnum_q   <= '0;
      wr_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (go) begin
            state_q    <= S_START;
            regnum_q   <= REG_W'(START);
            wr_en_q    <= 1'b1;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
          end
        end
        S_START: begin
          if (abort_w) begin
            state_q    <= S_IDLE;
            regnum_q   <= '0;
            wr_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
          end else if (!go) begin
            state_q    <= S_RUN;
            regnum_q   <= regnum_nxt;
            overflow_q <= ovf_nxt;
          end
        end
        S_RUN: begin
          if (abort_w) begin
            state_q    <= S_IDLE;
            regnum_q   <= '0;
            wr_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
          end else if (last_step) begin
            state_q  <= S_DONE;
            regnum_q <= '0;
            wr_en_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end else begin
            regnum_q   <= regnum_nxt;
            overflow_q <= overflow_q | ovf_nxt;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign regnum   = regnum_q;
  assign wr_en    = wr_en_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_reg_sequencer.sv
// Directed bench: default sequencer (START=8) plus a START=30 instance for wrap cases.
module tb_reg_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       go_a = 1'b0;
  logic       go_b = 1'b0;
  logic       direction = 1'b1;
  logic [1:0] stride = 2'd1;
`ifdef REG_SEQ_ABORT_EN
  logic       abort = 1'b0;
  logic       abort_b = 1'b0;
`endif

  logic [4:0] rn_a, rn_b;
  logic       we_a, we_b, busy_a, busy_b, done_a, done_b, ov_a, ov_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  reg_sequencer u_dut_a (
    .clock     (clock),
    .reset     (reset),
    .go        (go_a),
`ifdef REG_SEQ_ABORT_EN
    .abort     (abort),
`endif
    .direction (direction),
    .stride    (stride),
    .regnum    (rn_a),
    .wr_en     (we_a),
    .busy      (busy_a),
    .done      (done_a),
    .overflow  (ov_a)
  );

  reg_sequencer #(.REG_W(5), .START(30), .STEPS(4), .STRIDE_W(2)) u_dut_b (
    .clock     (clock),
    .reset     (reset),
    .go        (go_b),
`ifdef REG_SEQ_ABORT_EN
    .abort     (abort_b),
`endif
    .direction (direction),
    .stride    (stride),
    .regnum    (rn_b),
    .wr_en     (we_b),
    .busy      (busy_b),
    .done      (done_b),
    .overflow  (ov_b)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_idle_a(input string tag, input int exp_done);
    check({tag, " regnum"}, int'(rn_a), 0);
    check({tag, " wr_en"}, int'(we_a), 0);
    check({tag, " busy"}, int'(busy_a), 0);
    check({tag, " done"}, int'(done_a), exp_done);
  endtask

  // Runs one full sequence; exp_rn/exp_ov give every wr_en cycle's regnum/overflow.
  task automatic seq(input string tag, input bit use_b, input int hold, input logic d,
                     input logic [1:0] s, input int exp_rn[$], input int exp_ov[$]);
    direction = d;
    stride    = s;
    if (use_b) go_b = 1'b1; else go_a = 1'b1;
    foreach (exp_rn[i]) begin
      tick();
      check($sformatf("%s regnum[%0d]", tag, i), int'(use_b ? rn_b : rn_a), exp_rn[i]);
      check($sformatf("%s wr_en[%0d]", tag, i), int'(use_b ? we_b : we_a), 1);
      check($sformatf("%s busy[%0d]", tag, i), int'(use_b ? busy_b : busy_a), 1);
      check($sformatf("%s ovf[%0d]", tag, i), int'(use_b ? ov_b : ov_a), exp_ov[i]);
      if (i == hold - 1) begin
        go_a = 1'b0;
        go_b = 1'b0;
      end
    end
    tick();
    check({tag, " done"}, int'(use_b ? done_b : done_a), 1);
    check({tag, " done regnum"}, int'(use_b ? rn_b : rn_a), 0);
    check({tag, " done wr_en"}, int'(use_b ? we_b : we_a), 0);
    check({tag, " done busy"}, int'(use_b ? busy_b : busy_a), 0);
    check({tag, " done ovf hold"}, int'(use_b ? ov_b : ov_a), exp_ov[exp_rn.size()-1]);
  endtask

  initial begin
    // go high during reset must be ignored until the first edge with reset released
    go_a = 1'b1;
    tick();
    tick();
    check_idle_a("reset", 0);
    check("reset ovf", int'(ov_a), 0);
    check("reset b wr_en", int'(we_b), 0);
    go_a = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check_idle_a("post-reset", 0);

    // No combinational path from go to outputs
    go_a = 1'b1;
    #1;
    check("go comb wr_en", int'(we_a), 0);
    go_a = 1'b0;

    seq("up1", 1'b0, 1, 1'b1, 2'd1, '{8, 9, 10, 11, 12}, '{0, 0, 0, 0, 0});
    tick();
    check("done holds", int'(done_a), 1);

    seq("dn2hold3", 1'b0, 3, 1'b0, 2'd2, '{8, 8, 8, 6, 4, 2, 0}, '{0, 0, 0, 0, 0, 0, 0});
    seq("wrap30", 1'b1, 1, 1'b1, 2'd3, '{30, 1, 4, 7, 10}, '{0, 1, 1, 1, 1});
    seq("ovfclr", 1'b1, 1, 1'b0, 2'd1, '{30, 29, 28, 27, 26}, '{0, 0, 0, 0, 0});
    seq("stride0", 1'b0, 1, 1'b0, 2'd0, '{8, 7, 6, 5, 4}, '{0, 0, 0, 0, 0});
    seq("dnwrap", 1'b0, 1, 1'b0, 2'd3, '{8, 5, 2, 31, 28}, '{0, 0, 0, 1, 1});

    // Changes to direction/stride during RUN are ignored
    direction = 1'b1;
    stride    = 2'd1;
    go_a      = 1'b1;
    tick();
    go_a = 1'b0;
    tick();
    check("latch run1", int'(rn_a), 9);
    direction = 1'b0;
    stride    = 2'd3;
    go_a      = 1'b1;
    tick();
    check("latch run2", int'(rn_a), 10);
    go_a = 1'b0;
    repeat (3) tick();
    check("latch done", int'(done_a), 1);

    // Reset between edges while in RUN
    seq_start_mid();
    #2;
    reset = 1'b0;
    #1;
    check_idle_a("async reset", 0);
    check("async reset ovf", int'(ov_a), 0);
    tick();
    reset = 1'b1;
    tick();
    check_idle_a("after release", 0);
    seq("restart", 1'b0, 1, 1'b1, 2'd1, '{8, 9, 10, 11, 12}, '{0, 0, 0, 0, 0});

`ifdef REG_SEQ_ABORT_EN
    direction = 1'b1;
    stride    = 2'd1;
    go_a      = 1'b1;
    tick();
    go_a = 1'b0;
    tick();
    tick();
    check("abort pre", int'(rn_a), 10);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_idle_a("abort", 0);
    check("abort ovf", int'(ov_a), 0);
    repeat (4) tick();
    check("abort no done", int'(done_a), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  task automatic seq_start_mid();
    direction = 1'b1;
    stride    = 2'd1;
    go_a      = 1'b1;
    tick();
    go_a = 1'b0;
    tick();
    tick();
    check("mid run regnum", int'(rn_a), 10);
  endtask

endmodule
